// File: rtl/i2c_sda_return.sv
// Return-path SDA tracker for the I2C fan-out extender: decodes upstream traffic, decides who owns SDA
// and drives the wired-AND of the enabled downstream lines upstream. Define I2C_RET_TIMEOUT_EN for the stall abort.
module i2c_sda_return #(
    parameter int NCH            = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           scl_in,
    input  logic           sda_in,
    input  logic [NCH-1:0] sda_ret_in,
    input  logic [NCH-1:0] ch_en,
    output logic           sda_up_oe,
    output logic           dir_up,
    output logic           busy,
    output logic           timeout
);
    localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, HOLD
    } state_t;

    logic [SS-1:0]           scl_sync_q, sda_sync_q;
    logic [SS-1:0][NCH-1:0]  ret_sync_q;
    logic                    scl_prev_q, sda_prev_q;
    logic                    scl_s, sda_s, merged;
    logic                    scl_rise, scl_fall, start_det, stop_det;
    state_t                  state_q, state_d;
    logic [3:0]              bit_cnt_q, bit_cnt_d;
    logic                    rw_q, rw_d, ack_q, ack_d;
    logic                    dir_d, sda_up_oe_q, timeout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            ret_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SS-2:0], scl_in};
            sda_sync_q <= {sda_sync_q[SS-2:0], sda_in};
            ret_sync_q <= {ret_sync_q[SS-2:0], sda_ret_in};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s  = scl_sync_q[SS-1];
    assign sda_s  = sda_sync_q[SS-1];
    // A disabled channel reads as released, so an empty mask merges to 1 (NACK).
    assign merged = &(ret_sync_q[SS-1] | ~ch_en);

    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & sda_prev_q & ~sda_s & ~dir_up;
    assign stop_det  = scl_s & ~sda_prev_q & sda_s & ~dir_up;

    assign dir_up    = (state_q == ADDR_ACK) || (state_q == WR_ACK) || (state_q == RD_DATA);
    assign busy      = (state_q != IDLE);
    assign sda_up_oe = sda_up_oe_q;
    assign timeout   = timeout_q;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rw_d      = rw_q;
        ack_d     = ack_q;
        if (scl_rise) begin
            case (state_q)
                ADDR, WR_DATA, RD_DATA: begin
                    if (bit_cnt_q < 4'd8) bit_cnt_d = bit_cnt_q + 4'd1;
                    if (state_q == ADDR && bit_cnt_q == 4'd7) rw_d = sda_s;
                end
                ADDR_ACK, WR_ACK: ack_d = ~merged;
                RD_ACK:           ack_d = ~sda_s;
                default: ;
            endcase
        end
        if (scl_fall) begin
            case (state_q)
                ADDR:     if (bit_cnt_q == 4'd8) state_d = ADDR_ACK;
                ADDR_ACK: state_d = !ack_q ? HOLD : (rw_q ? RD_DATA : WR_DATA);
                WR_DATA:  if (bit_cnt_q == 4'd8) state_d = WR_ACK;
                WR_ACK:   state_d = ack_q ? WR_DATA : HOLD;
                RD_DATA:  if (bit_cnt_q == 4'd8) state_d = RD_ACK;
                RD_ACK:   state_d = ack_q ? RD_DATA : HOLD;
                default: ;
            endcase
        end
        if (state_d != state_q) bit_cnt_d = '0;
        // START/STOP override any concurrent SCL-edge decision; a stall abort overrides everything.
        if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
        end else if (stop_det) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
        end
        if (timeout_q) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
        end
        dir_d = (state_d == ADDR_ACK) || (state_d == WR_ACK) || (state_d == RD_DATA);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            rw_q        <= 1'b0;
            ack_q       <= 1'b0;
            sda_up_oe_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rw_q        <= rw_d;
            ack_q       <= ack_d;
            sda_up_oe_q <= dir_d & ~merged;
        end
    end

`ifdef I2C_RET_TIMEOUT_EN
    logic [15:0] to_cnt_q, to_cnt_d;
    logic        timeout_d;

    always_comb begin
        to_cnt_d  = '0;
        timeout_d = 1'b0;
        if (busy && !scl_rise && !scl_fall && !timeout_q) begin
            to_cnt_d  = to_cnt_q + 16'd1;
            timeout_d = (to_cnt_q == 16'(TIMEOUT_CYCLES - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
        end
    end
`else
    // Without the abort the stall limit has no effect; this folds to constant 0.
    assign timeout_q = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_i2c_sda_return.sv
// Directed bench for i2c_sda_return: bus-phase expectations delayed by the sync latency, checked every cycle.
`timescale 1ns/1ps
module tb_i2c_sda_return;
    localparam int NCH = 8;
    localparam int Q   = 4;     // clk cycles per SCL half-phase step
    localparam int LAT = 3;     // pin edge to output change

    logic           clk = 1'b0, rst = 1'b1, scl_in = 1'b1, sda_in = 1'b1;
    logic [NCH-1:0] sda_ret_in = '1, ch_en = '0, ret_idle = '1;
    logic           sda_up_oe, dir_up, busy, timeout;

    int   checks = 0, failures = 0, n_dir = 0, n_oe = 0;
    logic exp_busy = 1'b0, exp_dir = 1'b0;
    bit   cmp_en = 1'b0, cnt_en = 1'b0;
    logic [2:0] h0 = '0, h1 = '0, h2 = '0;   // {busy, dir_up, sda_up_oe} expectation history

    i2c_sda_return #(.NCH(NCH), .SYNC_STAGES(2), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst(rst), .scl_in(scl_in), .sda_in(sda_in),
        .sda_ret_in(sda_ret_in), .ch_en(ch_en),
        .sda_up_oe(sda_up_oe), .dir_up(dir_up), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    function automatic logic pulled(input logic [NCH-1:0] r, input logic [NCH-1:0] en);
        return |(~r & en);
    endfunction

    task automatic chk1(input string nm, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at %0t: got %b required %b", nm, $time, act, req);
        end
    endtask

    task automatic chkn(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s at %0t: got %0d required %0d", nm, $time, act, req);
        end
    endtask

    // Expectations set when pins change become visible LAT edges later; reset clears them at once.
    initial forever begin
        @(posedge clk);
        if (rst) begin
            h0 = '0; h1 = '0; h2 = '0;
        end else begin
            h2 = h1; h1 = h0;
            h0 = {exp_busy, exp_dir, exp_dir & pulled(sda_ret_in, ch_en)};
        end
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            chk1("cyc_busy", busy, h2[2]);
            chk1("cyc_dir_up", dir_up, h2[1]);
            chk1("cyc_sda_up_oe", sda_up_oe, h2[0]);
            chk1("cyc_timeout", timeout, 1'b0);
        end
        if (cnt_en) begin
            if (dir_up === 1'b1) n_dir++;
            if (sda_up_oe === 1'b1) n_oe++;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic waitq();
        repeat (Q) tick();
    endtask

    task automatic start_cond();
        sda_in = 1'b1; waitq();
        scl_in = 1'b1; waitq();
        sda_in = 1'b0; exp_busy = 1'b1; waitq();
        scl_in = 1'b0; waitq();
    endtask

    task automatic stop_cond(input bit timed);
        sda_in = 1'b0; waitq();
        scl_in = 1'b1; waitq();
        sda_in = 1'b1; exp_busy = 1'b0; exp_dir = 1'b0;
        if (timed) begin
            tick(); chk1("busy_stop_plus1", busy, 1'b1);
            tick(); chk1("busy_stop_plus2", busy, 1'b1);
            tick(); chk1("busy_stop_plus3", busy, 1'b0);
        end
        waitq(); waitq();
    endtask

    // One SCL period; samples the outputs just before SCL falls.
    task automatic send_bit(input logic m_sda, input logic [NCH-1:0] ret, input logic dir_after,
                            output logic oe_s, output logic dir_s);
        sda_in = m_sda; sda_ret_in = ret; waitq();
        scl_in = 1'b1; waitq();
        oe_s = sda_up_oe; dir_s = dir_up;
        scl_in = 1'b0; exp_dir = dir_after; waitq();
    endtask

    task automatic master_byte(input logic [7:0] b);
        logic o, d;
        for (int i = 7; i >= 0; i--) send_bit(b[i], ret_idle, (i == 0), o, d);
    endtask

    task automatic read_byte(input logic [7:0] data, output logic [7:0] oe_bits);
        logic o, d;
        logic [NCH-1:0] r;
        for (int i = 7; i >= 0; i--) begin
            r = ret_idle; r[0] = data[i];
            send_bit(1'b1, r, (i != 0), o, d);
            oe_bits[i] = o;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish within time limit");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        logic o, d;
        logic [7:0] ob;
        logic [7:0] rd;
        int n;

        repeat (3) tick();
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_dir_up", dir_up, 1'b0);
        chk1("reset_sda_up_oe", sda_up_oe, 1'b0);
        chk1("reset_timeout", timeout, 1'b0);
        rst = 1'b0; cmp_en = 1'b1;
        waitq();

        // Write 0x50 + data 0xA5, target on channel 3 acks both
        ch_en = 8'h08; ret_idle = '1; n_dir = 0; n_oe = 0; cnt_en = 1'b1;
        start_cond();
        master_byte(8'h50);
        send_bit(1'b1, 8'hF7, 1'b0, o, d);
        chk1("wr_addr_ack_dir", d, 1'b1); chk1("wr_addr_ack_oe", o, 1'b1);
        master_byte(8'hA5);
        send_bit(1'b1, 8'hF7, 1'b0, o, d);
        chk1("wr_data_ack_dir", d, 1'b1); chk1("wr_data_ack_oe", o, 1'b1);
        stop_cond(1'b1);
        cnt_en = 1'b0;
        chkn("wr_dir_cycles", n_dir, 2 * 3 * Q);
        chkn("wr_oe_cycles", n_oe, 2 * 2 * Q);

        // Read 0x51, channel 0 returns 0x3C, master NACKs
        ch_en = 8'h01; ret_idle = '1;
        start_cond();
        master_byte(8'h51);
        send_bit(1'b1, 8'hFE, 1'b1, o, d);
        chk1("rd_addr_ack_dir", d, 1'b1); chk1("rd_addr_ack_oe", o, 1'b1);
        read_byte(8'h3C, ob);
        chkn("rd_oe_bits", int'(ob), 8'hC3);
        send_bit(1'b1, ret_idle, 1'b0, o, d);
        chk1("rd_ack_dir", d, 1'b0);
        chk1("rd_hold_busy", busy, 1'b1);
        stop_cond(1'b0);
        chk1("rd_idle_busy", busy, 1'b0);

        // Address NACK, then repeated START and an acked address
        ch_en = 8'hFF; ret_idle = '1;
        start_cond();
        master_byte(8'h50);
        send_bit(1'b1, 8'hFF, 1'b0, o, d);
        chk1("nack_ack_dir", d, 1'b1); chk1("nack_ack_oe", o, 1'b0);
        chk1("nack_hold_dir", dir_up, 1'b0); chk1("nack_hold_busy", busy, 1'b1);
        start_cond();
        master_byte(8'h50);
        send_bit(1'b1, 8'hFE, 1'b0, o, d);
        chk1("rs_ack_dir", d, 1'b1); chk1("rs_ack_oe", o, 1'b1);
        stop_cond(1'b0);

        // Empty channel mask with a downstream line stuck low
        sda_ret_in = 8'hFB; ret_idle = 8'hFB; ch_en = 8'h00; waitq();
        n_oe = 0; cnt_en = 1'b1;
        start_cond();
        master_byte(8'h50);
        send_bit(1'b1, 8'hFB, 1'b0, o, d);
        chk1("mask0_ack_dir", d, 1'b1); chk1("mask0_ack_oe", o, 1'b0);
        chk1("mask0_hold_dir", dir_up, 1'b0); chk1("mask0_hold_busy", busy, 1'b1);
        stop_cond(1'b0);
        cnt_en = 1'b0;
        chkn("mask0_oe_cycles", n_oe, 0);
        ret_idle = '1; sda_ret_in = '1; waitq();

        // Reset during read bit 4
        ch_en = 8'h01; rd = 8'h3C;
        start_cond();
        master_byte(8'h51);
        send_bit(1'b1, 8'hFE, 1'b1, o, d);
        for (int i = 7; i >= 5; i--) send_bit(1'b1, {7'h7F, rd[i]}, 1'b1, o, d);
        sda_in = 1'b1; sda_ret_in = {7'h7F, rd[4]}; waitq();
        scl_in = 1'b1; waitq();
        rst = 1'b1; exp_busy = 1'b0; exp_dir = 1'b0;
        tick();
        chk1("rst_busy", busy, 1'b0); chk1("rst_dir_up", dir_up, 1'b0);
        chk1("rst_sda_up_oe", sda_up_oe, 1'b0); chk1("rst_timeout", timeout, 1'b0);
        tick(); rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            scl_in = 1'b0; waitq();
            sda_in = k[0]; sda_ret_in = 8'h00; waitq();
            scl_in = 1'b1; waitq();
        end
        scl_in = 1'b0; waitq();
        sda_in = 1'b1; sda_ret_in = '1; waitq();
        scl_in = 1'b1; waitq();
        chk1("post_rst_busy", busy, 1'b0);
        chk1("post_rst_dir_up", dir_up, 1'b0);

`ifdef I2C_RET_TIMEOUT_EN
        // SCL held low in ADDR_ACK until the stall abort fires
        cmp_en = 1'b0; ch_en = 8'h01; ret_idle = '1;
        start_cond();
        rd = 8'h50;
        for (int i = 7; i >= 1; i--) send_bit(rd[i], ret_idle, 1'b0, o, d);
        sda_in = rd[0]; waitq();
        scl_in = 1'b1; waitq();
        scl_in = 1'b0;
        n = 0;
        while (timeout !== 1'b1 && n < 400) begin
            tick(); n++;
        end
        chkn("to_cycles", n, LAT + 100);
        tick();
        chk1("to_pulse_end", timeout, 1'b0);
        chk1("to_dir_up", dir_up, 1'b0);
        chk1("to_busy", busy, 1'b0);
        chk1("to_sda_up_oe", sda_up_oe, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/i2c_sda_return.md
Name: i2c_sda_return

Overview:
Return-path companion to the I2C fan-out extender. It decodes the upstream master's bus activity and tracks which side owns SDA: the master, or the downstream targets during ACKs and read data. When the downstream side owns SDA, it wired-ANDs the enabled downstream SDA lines and drives the result back upstream. It also outputs `dir_up` so the fan-out path can tristate its downstream SDA drivers while targets drive the bus.

Parameters:
- NCH, 8, number of downstream channels.
- SYNC_STAGES, 2, synchronizer flops on scl_in/sda_in (minimum 2).
- TIMEOUT_CYCLES, 65535, clk cycles without an SCL edge before forced abort (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- scl_in  in  1  upstream SCL, async to clk
- sda_in  in  1  upstream SDA, async to clk
- sda_ret_in  in  NCH  downstream SDA readback, one bit per channel, async
- ch_en  in  NCH  channel participation mask, quasi-static
- sda_up_oe  out  1  1 = pull upstream SDA low
- dir_up  out  1  1 = downstream owns SDA; fan-out must release downstream SDA
- busy  out  1  1 between START and STOP
- timeout  out  1  1-cycle abort pulse (optional feature)

Behaviour:
- Reset:
  - State IDLE; bit_cnt=0.
  - sda_up_oe=0, dir_up=0, busy=0, timeout=0.
  - Synchronizer flops preset to 1.
- Synchronization:
  - scl_in, sda_in and sda_ret_in each pass through SYNC_STAGES flops.
  - Edges are detected against a one-cycle-delayed copy.
  - Total latency from pin edge to output change is SYNC_STAGES+1 clk cycles (3 at default).
- START: synced SDA falls while synced SCL is high and dir_up=0.
  - Go to ADDR, bit_cnt=0, busy=1.
  - Accepted in any state, including repeated START.
- STOP: synced SDA rises while synced SCL is high and dir_up=0.
  - Go to IDLE, busy=0.
- While dir_up=1, START/STOP detection is suppressed.
- On each SCL rising edge, bit_cnt increments (0..7) in ADDR/WR_DATA/RD_DATA. On the 8th ADDR bit, the SDA value is latched as rw.
- State transitions occur only on SCL falling edges:
  - ADDR, bit_cnt==8 -> ADDR_ACK; dir_up=1; bit_cnt=0.
  - ADDR_ACK -> depends on the ACK sampled at the SCL rising edge (merged SDA):
    - ACK with rw=1 -> RD_DATA, dir_up=1.
    - ACK with rw=0 -> WR_DATA, dir_up=0.
    - NACK -> HOLD, dir_up=0.
  - WR_DATA, 8 bits -> WR_ACK, dir_up=1.
  - WR_ACK -> ACK: WR_DATA, dir_up=0; NACK: HOLD, dir_up=0.
  - RD_DATA, 8 bits -> RD_ACK, dir_up=0 (master acks).
  - RD_ACK -> ACK (upstream SDA low): RD_DATA, dir_up=1; NACK: HOLD, dir_up=0.
  - HOLD: dir_up=0; waits for START or STOP.
- Merge:
  - merged = AND over i of (sda_ret_in[i] | ~ch_en[i]).
  - If ch_en is all zeros, merged=1 (reads as NACK).
- sda_up_oe is registered: sda_up_oe <= dir_up & ~merged. It never asserts while dir_up=0.
- Simultaneous SCL falling edge and START/STOP cannot occur after synchronization (same line sampled once). If it does, START/STOP wins.
- Reset mid-transaction: next cycle all outputs are 0 and the state is IDLE. Traffic is ignored until a fresh START.
- bit_cnt is 4 bits wide, saturates at 8, and is cleared on every state transition.

Optional Feature:
Macro: I2C_RET_TIMEOUT_EN.
- Defined:
  - A 16-bit counter runs while busy=1 and resets on every synced SCL edge.
  - On reaching TIMEOUT_CYCLES it pulses timeout for 1 cycle, then forces IDLE with dir_up=0, sda_up_oe=0 and busy=0.
- Undefined: no counter; the timeout port is tied to 0.

Test Plan:
1. Write 0x50 (addr 0x28, W), target ACKs on ch 3 (ch_en=0x08), one data byte 0xA5 ACKed:
   - dir_up=1 exactly during both ACK bit periods.
   - sda_up_oe=1 during ACKs.
   - busy falls 3 clk after STOP.
2. Read 0x51, target ch 0 returns 0x3C, master NACKs:
   - sda_up_oe mirrors ~0x3C bits during RD_DATA.
   - dir_up=0 in RD_ACK.
   - State HOLD, then IDLE at STOP.
3. Address NACK (all sda_ret_in=1, ch_en=0xFF):
   - Sequence is ADDR_ACK -> HOLD.
   - dir_up=0 and sda_up_oe=0 from the following SCL fall.
   - Repeated START returns to ADDR.
4. ch_en=0x00 with a downstream line held low: sda_up_oe stays 0 and the address is treated as NACK.
5. Assert rst during RD_DATA bit 4:
   - Next cycle all outputs are 0.
   - Subsequent SCL toggles without START leave busy=0.
6. (I2C_RET_TIMEOUT_EN, TIMEOUT_CYCLES=100) SCL stuck low after ADDR_ACK:
   - timeout pulses at cycle 100.
   - dir_up=0 and busy=0 on the next cycle.
